// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_unit
//  Description : Load/store unit between a CPU pipeline and a single-port
//                SRAM. Accepts one operation at a time, checks it for
//                illegal/misaligned exceptions, issues one SRAM access with
//                lane-aligned byte enables and replicated store data, and
//                returns sign/zero-extended load data after RD_LAT cycles.
//  Ports       : clk, reset          - clock, synchronous active-high reset
//                req_*               - operation request (valid/ready)
//                resp_*              - single-cycle completion, data, exception
//                stall               - pipeline hold request
//                sram_*              - SRAM strobe, byte enables, address, data
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_access_unit #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [2:0]          req_op,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                resp_valid,
    output logic [DATA_W-1:0]   resp_rdata,
    output logic [1:0]          resp_exc,
    output logic                stall,
    output logic                sram_en,
    output logic [DATA_W/8-1:0] sram_wen,
    output logic [ADDR_W-1:0]   sram_addr,
    output logic [DATA_W-1:0]   sram_wdata,
    input  logic [DATA_W-1:0]   sram_rdata
);

    localparam int NB     = DATA_W / 8;
    localparam int LANE_W = $clog2(NB);
    localparam int CNT_W  = $clog2(RD_LAT + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam logic [1:0] EXC_OK    = 2'b00;
    localparam logic [1:0] EXC_ALIGN = 2'b01;
    localparam logic [1:0] EXC_ILL   = 2'b10;

    logic [1:0]        state_q, state_d;
    logic [2:0]        op_q;
    logic              we_q;
    logic [LANE_W-1:0] lane_q;
    logic [1:0]        exc_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] rdata_q;
    logic [ADDR_W-1:0] addr_q;
    logic [NB-1:0]     wen_q;
    logic [DATA_W-1:0] wdata_q;

    logic              w_accept;
    logic              w_illegal;
    logic              w_misal;
    logic [1:0]        w_exc;
    logic [LANE_W-1:0] w_lane;
    logic [NB-1:0]     w_size_mask;
    logic [NB-1:0]     w_wen;
    logic [DATA_W-1:0] w_wdata_rep;
    logic [DATA_W-1:0] w_shift;
    logic [DATA_W-1:0] w_load_ext;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    assign w_accept = req_valid && (state_q == S_IDLE);
    assign w_lane   = req_addr[LANE_W-1:0];

    // Doubleword only exists on a 64-bit SRAM; unsigned stores are meaningless.
    assign w_illegal = (req_op == 3'b111)
                    || ((req_op == 3'b011) && (DATA_W == 32))
                    || (req_we && req_op[2]);

    always_comb begin
        w_misal     = 1'b0;
        w_size_mask = '0;
        w_wdata_rep = req_wdata;
        case (req_op[1:0])
            2'b00: begin
                w_misal     = 1'b0;
                w_size_mask = NB'(1);
                w_wdata_rep = {NB{req_wdata[7:0]}};
            end
            2'b01: begin
                w_misal     = req_addr[0];
                w_size_mask = NB'(2'b11);
                w_wdata_rep = {(DATA_W/16){req_wdata[15:0]}};
            end
            2'b10: begin
                w_misal     = |req_addr[1:0];
                w_size_mask = NB'(4'hF);
                w_wdata_rep = {(DATA_W/32){req_wdata[31:0]}};
            end
            default: begin
                w_misal     = |req_addr[2:0];
                w_size_mask = '1;
                w_wdata_rep = req_wdata;
            end
        endcase
    end

    // Illegal wins over misaligned.
    assign w_exc = w_illegal ? EXC_ILL : (w_misal ? EXC_ALIGN : EXC_OK);
    assign w_wen = req_we ? (w_size_mask << w_lane) : '0;

    // ------------------------------------------------------------------
    // Load data lane extraction and extension
    // ------------------------------------------------------------------
    assign w_shift = sram_rdata >> {lane_q, 3'b000};

    always_comb begin
        w_load_ext = w_shift;
        case (op_q)
            3'b000:  w_load_ext = DATA_W'($signed(w_shift[7:0]));
            3'b001:  w_load_ext = DATA_W'($signed(w_shift[15:0]));
            3'b010:  w_load_ext = DATA_W'($signed(w_shift[31:0]));
            3'b100:  w_load_ext = DATA_W'(w_shift[7:0]);
            3'b101:  w_load_ext = DATA_W'(w_shift[15:0]);
            3'b110:  w_load_ext = DATA_W'(w_shift[31:0]);
            default: w_load_ext = w_shift;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    // Excepting operations never touch the SRAM.
                    state_d = (w_exc != EXC_OK) ? S_RESP : S_ISSUE;
                end
            end
            S_ISSUE: state_d = we_q ? S_RESP : S_WAIT;
            S_WAIT:  state_d = (cnt_q == '0) ? S_RESP : S_WAIT;
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        req_ready  = (state_q == S_IDLE);
        resp_valid = (state_q == S_RESP);
        resp_exc   = (state_q == S_RESP) ? exc_q : EXC_OK;
        sram_en    = (state_q == S_ISSUE);
        sram_wen   = (state_q == S_ISSUE) ? wen_q : '0;
        stall      = (req_valid && (state_q != S_IDLE))
                  || (state_q == S_ISSUE) || (state_q == S_WAIT);
    end

    assign resp_rdata = rdata_q;
    assign sram_addr  = addr_q;
    assign sram_wdata = wdata_q;

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            op_q    <= '0;
            we_q    <= 1'b0;
            lane_q  <= '0;
            exc_q   <= EXC_OK;
            cnt_q   <= '0;
            rdata_q <= '0;
            addr_q  <= '0;
            wen_q   <= '0;
            wdata_q <= '0;
        end else begin
            if (w_accept) begin
                op_q   <= req_op;
                we_q   <= req_we;
                lane_q <= w_lane;
                exc_q  <= w_exc;
                if (w_exc != EXC_OK) begin
                    // Response appears next cycle, so clear the data now.
                    rdata_q <= '0;
                end else begin
                    addr_q  <= {req_addr[ADDR_W-1:LANE_W], {LANE_W{1'b0}}};
                    wen_q   <= w_wen;
                    wdata_q <= w_wdata_rep;
                end
            end

            if (state_q == S_ISSUE) begin
                cnt_q <= CNT_W'(RD_LAT - 1);
                if (we_q) begin
                    rdata_q <= '0;
                end
            end

            if (state_q == S_WAIT) begin
                if (cnt_q == '0) begin
                    rdata_q <= w_load_ext;
                end else begin
                    cnt_q <= cnt_q - 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_access_unit
//  Description : Directed self-checking bench for mem_access_unit. Three
//                instances (RD_LAT 1, 3, 4) share the request inputs; each has
//                its own SRAM read model that returns the programmed word only
//                in the cycle the read latency says, and a filler otherwise.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

    localparam int DW = 32;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid;
    logic          req_we;
    logic [2:0]    req_op;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic [DW-1:0] mem1, mem3, mem4;

    logic          u1_ready, u1_rv, u1_stall, u1_en;
    logic [1:0]    u1_exc;
    logic [DW-1:0] u1_rdata, u1_wdata, u1_srd;
    logic [3:0]    u1_wen;
    logic [AW-1:0] u1_addr;

    logic          u3_ready, u3_rv, u3_stall, u3_en;
    logic [1:0]    u3_exc;
    logic [DW-1:0] u3_rdata, u3_wdata, u3_srd;
    logic [3:0]    u3_wen;
    logic [AW-1:0] u3_addr;

    logic          u4_ready, u4_rv, u4_stall, u4_en;
    logic [1:0]    u4_exc;
    logic [DW-1:0] u4_rdata, u4_wdata, u4_srd;
    logic [3:0]    u4_wen;
    logic [AW-1:0] u4_addr;

    logic [3:0]    p1, p3, p4;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(1)) u1 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(u1_ready),
        .req_we(req_we), .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(u1_rv), .resp_rdata(u1_rdata), .resp_exc(u1_exc), .stall(u1_stall),
        .sram_en(u1_en), .sram_wen(u1_wen), .sram_addr(u1_addr), .sram_wdata(u1_wdata),
        .sram_rdata(u1_srd)
    );

    mem_access_unit #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(3)) u3 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(u3_ready),
        .req_we(req_we), .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(u3_rv), .resp_rdata(u3_rdata), .resp_exc(u3_exc), .stall(u3_stall),
        .sram_en(u3_en), .sram_wen(u3_wen), .sram_addr(u3_addr), .sram_wdata(u3_wdata),
        .sram_rdata(u3_srd)
    );

    mem_access_unit #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(4)) u4 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(u4_ready),
        .req_we(req_we), .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(u4_rv), .resp_rdata(u4_rdata), .resp_exc(u4_exc), .stall(u4_stall),
        .sram_en(u4_en), .sram_wen(u4_wen), .sram_addr(u4_addr), .sram_wdata(u4_wdata),
        .sram_rdata(u4_srd)
    );

    // SRAM read models: data is valid RD_LAT cycles after the strobe cycle.
    always @(posedge clk) begin
        if (reset) begin
            p1 <= '0;
            p3 <= '0;
            p4 <= '0;
        end else begin
            p1 <= {p1[2:0], u1_en};
            p3 <= {p3[2:0], u3_en};
            p4 <= {p4[2:0], u4_en};
        end
    end

    assign u1_srd = p1[0] ? mem1 : 32'hDEAD_BEEF;
    assign u3_srd = p3[2] ? mem3 : 32'hDEAD_BEEF;
    assign u4_srd = p4[3] ? mem4 : 32'hDEAD_BEEF;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic drive(input logic we, input logic [2:0] op,
                         input logic [AW-1:0] addr, input logic [DW-1:0] wd);
        req_valid = 1'b1;
        req_we    = we;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wd;
    endtask

    logic seen;

    initial begin
        reset     = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_op    = 3'b000;
        req_addr  = '0;
        req_wdata = '0;
        mem1      = 32'h8000_0000;
        mem3      = 32'hFFFF_0000;
        mem4      = 32'h1234_5678;
        repeat (3) step();
        reset = 1'b0;

        // Reset state
        chk("rst_ready", u1_ready, 1);
        chk("rst_rv",    u1_rv, 0);
        chk("rst_exc",   u1_exc, 0);
        chk("rst_rdata", u1_rdata, 0);
        chk("rst_stall", u1_stall, 0);
        chk("rst_en",    u1_en, 0);
        chk("rst_wen",   u1_wen, 0);
        chk("rst_addr",  u1_addr, 0);
        chk("rst_wdata", u1_wdata, 0);

        // LB 0x1003, RD_LAT=1
        chk("lb_ready", u1_ready, 1);
        drive(1'b0, 3'b000, 32'h1003, 32'h0);
        step(); req_valid = 1'b0;
        chk("lb_en_t1",   u1_en, 1);
        chk("lb_addr",    u1_addr, 32'h1000);
        chk("lb_wen",     u1_wen, 0);
        chk("lb_stall1",  u1_stall, 1);
        chk("lb_rv_t1",   u1_rv, 0);
        step();
        chk("lb_en_t2",   u1_en, 0);
        chk("lb_rv_t2",   u1_rv, 0);
        chk("lb_stall2",  u1_stall, 1);
        step();
        chk("lb_rv_t3",   u1_rv, 1);
        chk("lb_rdata",   u1_rdata, 32'hFFFF_FF80);
        chk("lb_exc",     u1_exc, 0);
        chk("lb_stall3",  u1_stall, 0);
        step();
        chk("lb_rv_t4",   u1_rv, 0);
        chk("lb_hold",    u1_rdata, 32'hFFFF_FF80);
        repeat (4) step();

        // SH 0x2002
        drive(1'b1, 3'b001, 32'h2002, 32'h0000_ABCD);
        step(); req_valid = 1'b0; req_we = 1'b0;
        chk("sh_en",    u1_en, 1);
        chk("sh_addr",  u1_addr, 32'h2000);
        chk("sh_wen",   u1_wen, 4'b1100);
        chk("sh_wdata", u1_wdata, 32'hABCD_ABCD);
        chk("sh_rv_t1", u1_rv, 0);
        step();
        chk("sh_rv_t2", u1_rv, 1);
        chk("sh_exc",   u1_exc, 0);
        chk("sh_en_t2", u1_en, 0);
        chk("sh_wen_t2", u1_wen, 0);
        step();
        chk("sh_rv_t3", u1_rv, 0);

        // SB 0x0005
        drive(1'b1, 3'b000, 32'h0005, 32'h1234_5678);
        step(); req_valid = 1'b0; req_we = 1'b0;
        chk("sb_wen",   u1_wen, 4'b0010);
        chk("sb_wdata", u1_wdata, 32'h7878_7878);
        chk("sb_addr",  u1_addr, 32'h0004);
        step();
        chk("sb_rv",    u1_rv, 1);
        step();

        // LW misaligned
        drive(1'b0, 3'b010, 32'h1001, 32'h0);
        step(); req_valid = 1'b0;
        chk("lwm_rv",    u1_rv, 1);
        chk("lwm_exc",   u1_exc, 2'b01);
        chk("lwm_rdata", u1_rdata, 0);
        chk("lwm_en",    u1_en, 0);
        step();
        chk("lwm_rv2",   u1_rv, 0);
        chk("lwm_ready", u1_ready, 1);

        // LD on 32-bit SRAM
        drive(1'b0, 3'b011, 32'h0000, 32'h0);
        step(); req_valid = 1'b0;
        chk("ld_rv",  u1_rv, 1);
        chk("ld_exc", u1_exc, 2'b10);
        chk("ld_en",  u1_en, 0);
        step();

        // Unsigned store, also misaligned: illegal wins
        drive(1'b1, 3'b110, 32'h0003, 32'h0);
        step(); req_valid = 1'b0; req_we = 1'b0;
        chk("swu_exc", u1_exc, 2'b10);
        chk("swu_en",  u1_en, 0);
        chk("swu_wen", u1_wen, 0);
        step();

        // LHU 0x0006: RD_LAT=3 on u3, RD_LAT=1 on u1
        drive(1'b0, 3'b101, 32'h0006, 32'h0);
        step(); req_valid = 1'b0;
        chk("lhu3_en",   u3_en, 1);
        chk("lhu3_addr", u3_addr, 32'h0004);
        step();
        step();
        chk("lhu1_rv",    u1_rv, 1);
        chk("lhu1_rdata", u1_rdata, 32'h0000_8000);
        chk("lhu3_rv_t3", u3_rv, 0);
        chk("lhu3_stall", u3_stall, 1);
        step();
        chk("lhu3_rv_t4", u3_rv, 0);
        step();
        chk("lhu3_rv_t5", u3_rv, 1);
        chk("lhu3_rdata", u3_rdata, 32'h0000_FFFF);
        step();
        chk("lhu3_rv_t6", u3_rv, 0);
        repeat (2) step();

        // LH sign-extending, u1
        drive(1'b0, 3'b001, 32'h0002, 32'h0);
        step(); req_valid = 1'b0;
        step();
        step();
        chk("lh_rdata", u1_rdata, 32'hFFFF_8000);
        repeat (5) step();

        // Reset while u4 is in WAIT
        drive(1'b0, 3'b010, 32'h0000, 32'h0);
        step(); req_valid = 1'b0;
        step();
        chk("rw_stall_wait", u4_stall, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rw_ready", u4_ready, 1);
        chk("rw_stall", u4_stall, 0);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            seen = seen | u4_rv | u3_rv | u1_rv;
        end
        chk("rw_no_resp", seen, 0);

        // Back-to-back on u1 with req_valid held high
        drive(1'b0, 3'b010, 32'h0000, 32'h0);
        step();
        req_addr = 32'h0004;    // ignored until the next IDLE
        chk("bb_en1",    u1_en, 1);
        chk("bb_addr1",  u1_addr, 32'h0000);
        chk("bb_stall1", u1_stall, 1);
        step();
        chk("bb_stall2", u1_stall, 1);
        chk("bb_en_t2",  u1_en, 0);
        step();
        chk("bb_rv1",    u1_rv, 1);
        chk("bb_rdata1", u1_rdata, 32'h8000_0000);
        chk("bb_nready", u1_ready, 0);
        step();
        chk("bb_ready",  u1_ready, 1);
        chk("bb_rv_off", u1_rv, 0);
        chk("bb_stall4", u1_stall, 0);
        step(); req_valid = 1'b0;
        chk("bb_en2",    u1_en, 1);
        chk("bb_addr2",  u1_addr, 32'h0004);
        chk("bb_stall5", u1_stall, 1);
        step();
        step();
        chk("bb_rv2",    u1_rv, 1);
        repeat (8) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
